// File: rtl/ddr3_ba_lane_ctrl.sv
// DDR3 bank-address lane controller: turns four-phase DFI bank addresses into
// per-lane serializer words and sequences per-lane delay-line trim
// (load, settle, timed moves, range-error abort).
module ddr3_ba_lane_ctrl #(
  parameter int NUM_LANES     = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_TAPS      = 127
) (
  input  logic        i_fab_clk,
  input  logic        i_tx_sync_rst,
  input  logic [11:0] i_dfi_bank,
  input  logic [3:0]  i_dfi_cmd_valid,
  input  logic        i_oe_req,
  input  logic        i_trim_req,
  input  logic [1:0]  i_trim_lane,
  input  logic [7:0]  i_trim_taps,
  input  logic        i_trim_dir,
  output logic        o_trim_busy,
  output logic        o_trim_done,
  output logic        o_trim_err,
  output logic [3:0]  o_tx_data_0,
  output logic [3:0]  o_tx_data_1,
  output logic [3:0]  o_tx_data_2,
  output logic [3:0]  o_oe_data_0,
  output logic [3:0]  o_oe_data_1,
  output logic [3:0]  o_oe_data_2,
  output logic        o_odt_en_0,
  output logic        o_odt_en_1,
  output logic        o_odt_en_2,
  output logic        o_delay_line_load_0,
  output logic        o_delay_line_load_1,
  output logic        o_delay_line_load_2,
  output logic        o_delay_line_move_0,
  output logic        o_delay_line_move_1,
  output logic        o_delay_line_move_2,
  output logic        o_delay_line_direction_0,
  output logic        o_delay_line_direction_1,
  output logic        o_delay_line_direction_2,
  input  logic        i_delay_line_out_of_range_0,
  input  logic        i_delay_line_out_of_range_1,
  input  logic        i_delay_line_out_of_range_2
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_MOVE, S_GAP, S_DONE} state_t;

  localparam logic [7:0] MAX_TAPS_W  = 8'(MAX_TAPS);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // ---------------- data path ----------------
  logic [11:0]                r_bank_p0;
  logic [3:0]                 r_cvld_p0;
  logic                       r_oe_p0;
  logic [2:0]                 r_hold;
  logic [2:0]                 w_prev;
  logic [3:0][2:0]            w_res;
  logic [NUM_LANES-1:0][3:0]  w_tx;
  logic [NUM_LANES-1:0][3:0]  r_tx_p1;
  logic                       r_oe_p1;

  // Stage 0: capture the DFI phase words and OE request
  always_ff @(posedge i_fab_clk) begin
    if (i_tx_sync_rst) begin
      r_bank_p0 <= '0;
      r_cvld_p0 <= '0;
      r_oe_p0   <= 1'b0;
    end else begin
      r_bank_p0 <= i_dfi_bank;
      r_cvld_p0 <= i_dfi_cmd_valid;
      r_oe_p0   <= i_oe_req;
    end
  end

  // Resolve each phase: invalid phases repeat the previous phase's bank,
  // phase 0 falls back to the last bank of the prior cycle
  always_comb begin
    w_prev = r_hold;
    w_res  = '0;
    for (int p = 0; p < 4; p++) begin
      if (r_cvld_p0[p]) w_prev = r_bank_p0[3*p +: 3];
      w_res[p] = w_prev;
    end
  end

  // Transpose phase-major banks into one 4-bit word per address bit
  always_comb begin
    w_tx = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      for (int p = 0; p < 4; p++) begin
        w_tx[n][p] = w_res[p][n];
      end
    end
  end

  // Stage 1: serializer words and phase-hold register
  always_ff @(posedge i_fab_clk) begin
    if (i_tx_sync_rst) begin
      r_tx_p1 <= '0;
      r_oe_p1 <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_tx_p1 <= w_tx;
      r_oe_p1 <= r_oe_p0;
      r_hold  <= w_res[3];
    end
  end

  assign o_tx_data_0 = r_tx_p1[0];
  assign o_tx_data_1 = r_tx_p1[1];
  assign o_tx_data_2 = r_tx_p1[2];
  assign o_oe_data_0 = {4{r_oe_p1}};
  assign o_oe_data_1 = {4{r_oe_p1}};
  assign o_oe_data_2 = {4{r_oe_p1}};
  assign o_odt_en_0  = 1'b0;
  assign o_odt_en_1  = 1'b0;
  assign o_odt_en_2  = 1'b0;

  // ---------------- trim sequencer ----------------
  state_t                 r_state, w_next;
  logic [1:0]             r_lane;
  logic [7:0]             r_taps;
  logic                   r_dir;
  logic                   r_err;
  logic                   r_rej;
  logic [3:0]             r_wait;
  logic                   w_accept, w_reject, w_oor, w_wait_done, w_dir_on, w_oor_st;
  logic [NUM_LANES-1:0]   w_sel, w_oor_vec;

  assign w_accept    = (r_state == S_IDLE) && i_trim_req;
  assign w_reject    = (i_trim_lane == 2'd3) || (i_trim_taps > MAX_TAPS_W);
  assign w_oor_vec   = {i_delay_line_out_of_range_2, i_delay_line_out_of_range_1,
                        i_delay_line_out_of_range_0};
  assign w_oor       = |(w_sel & w_oor_vec);
  assign w_oor_st    = w_oor && ((r_state == S_SETTLE) || (r_state == S_MOVE) ||
                                 (r_state == S_GAP));
  assign w_wait_done = (r_wait == 4'd0);

  // One-hot decode of the latched lane; lane 3 selects nothing
  always_comb begin
    w_sel = '0;
    for (int n = 0; n < NUM_LANES; n++) w_sel[n] = (r_lane == 2'(n));
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_trim_req) w_next = w_reject ? S_DONE : S_LOAD;
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE, S_GAP: begin
        if (w_oor)            w_next = S_DONE;
        else if (w_wait_done) w_next = (r_taps == 8'd0) ? S_DONE : S_MOVE;
      end
      S_MOVE:   w_next = w_oor ? S_DONE : S_GAP;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register, settle timer and error status
  always_ff @(posedge i_fab_clk) begin
    if (i_tx_sync_rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_LOAD) || (r_state == S_MOVE)) r_wait <= SETTLE_LAST;
      else if (!w_wait_done)                          r_wait <= r_wait - 4'd1;
      if (w_accept) begin
        r_err <= w_reject;
        r_rej <= w_reject;
      end else if (w_oor_st) begin
        r_err <= 1'b1;
      end
    end
  end

  // Latched trim request; the tap count only decrements in MOVE, which is
  // entered solely with a non-zero count
  always_ff @(posedge i_fab_clk) begin
    if (w_accept) begin
      r_lane <= i_trim_lane;
      r_taps <= i_trim_taps;
      r_dir  <= i_trim_dir;
    end else if (r_state == S_MOVE) begin
      r_taps <= r_taps - 8'd1;
    end
  end

  assign w_dir_on = r_dir && ((r_state == S_LOAD) || (r_state == S_SETTLE) ||
                              (r_state == S_MOVE) || (r_state == S_GAP) ||
                              ((r_state == S_DONE) && !r_rej));

  assign o_trim_busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_trim_done = (r_state == S_DONE);
  assign o_trim_err  = r_err;

  assign o_delay_line_load_0      = (r_state == S_LOAD) && w_sel[0];
  assign o_delay_line_load_1      = (r_state == S_LOAD) && w_sel[1];
  assign o_delay_line_load_2      = (r_state == S_LOAD) && w_sel[2];
  assign o_delay_line_move_0      = (r_state == S_MOVE) && w_sel[0];
  assign o_delay_line_move_1      = (r_state == S_MOVE) && w_sel[1];
  assign o_delay_line_move_2      = (r_state == S_MOVE) && w_sel[2];
  assign o_delay_line_direction_0 = w_dir_on && w_sel[0];
  assign o_delay_line_direction_1 = w_dir_on && w_sel[1];
  assign o_delay_line_direction_2 = w_dir_on && w_sel[2];

endmodule
